// File: rtl/alu.sv
// 32-bit integer ALU for the execute stage.
// A 4-bit control code picks one of twelve operations on two 32-bit
// operands. The result and the zero/negative/carry/overflow flags are
// registered, so everything appears one clock after the inputs.
// Unused control codes produce a zero result.

module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  control,
  input  logic [31:0] data_in1,
  input  logic [31:0] data_in2,
  output logic [31:0] data_out,
  output logic        zero,
  output logic        negative,
  output logic        carry,
  output logic        overflow
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0100,
    OP_XOR   = 4'b0110,
    OP_NOR   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_SRL   = 4'b1010,
    OP_SRA   = 4'b1011,
    OP_SLT   = 4'b1100,
    OP_SLL   = 4'b1110,
    OP_PASSB = 4'b1111
  } aluOp_e;

  // Registered outputs.
  logic [31:0] r_dataOut;
  logic        r_zero;
  logic        r_negative;
  logic        r_carry;
  logic        r_overflow;

  // Adder / subtractor.
  // Subtraction reuses the adder as A + ~B + 1, so bit 32 of the sum is
  // the "no borrow" indication.
  logic        w_isSub;
  logic [31:0] w_addOperandB;
  logic [32:0] w_addSum;
  logic        w_addOverflow;

  assign w_isSub       = (control == OP_SUB);
  assign w_addOperandB = w_isSub ? ~data_in2 : data_in2;
  assign w_addSum      = {1'b0, data_in1} + {1'b0, w_addOperandB} + {32'd0, w_isSub};

  // Signed overflow: both addends share a sign that the sum does not.
  // With B inverted for subtraction this is the same as "A and B differ
  // in sign and the result sign differs from A".
  assign w_addOverflow = (data_in1[31] == w_addOperandB[31]) &&
                         (w_addSum[31] != data_in1[31]);

  // Comparators for SLT / SLTU.
  // When the signs differ, the negative operand is the smaller one;
  // otherwise the unsigned comparison gives the signed answer as well.
  logic w_lessUnsigned;
  logic w_lessSigned;

  assign w_lessUnsigned = (data_in1 < data_in2);
  assign w_lessSigned   = (data_in1[31] ^ data_in2[31]) ? data_in1[31] : w_lessUnsigned;

  // Barrel shifter.
  // One right-shifting barrel serves all three shifts: a left shift is
  // done by bit-reversing A on the way in and the result on the way out.
  // Only the low five bits of B form the shift amount.
  logic        w_isLeftShift;
  logic        w_shiftFill;
  logic [4:0]  w_shiftAmount;
  logic [31:0] w_reversedA;
  logic [31:0] w_shiftIn;
  logic [31:0] w_stage1;
  logic [31:0] w_stage2;
  logic [31:0] w_stage4;
  logic [31:0] w_stage8;
  logic [31:0] w_stage16;
  logic [31:0] w_reversedOut;
  logic [31:0] w_shiftResult;

  assign w_isLeftShift = (control == OP_SLL);
  assign w_shiftFill   = (control == OP_SRA) ? data_in1[31] : 1'b0;
  assign w_shiftAmount = data_in2[4:0];

  // Mirror operand A so the right-shift barrel can perform SLL.
  always_comb begin
    w_reversedA = '0;
    for (int i = 0; i < 32; i++) begin
      w_reversedA[i] = data_in1[31-i];
    end
  end

  assign w_shiftIn = w_isLeftShift ? w_reversedA : data_in1;

  assign w_stage1  = w_shiftAmount[0] ? {w_shiftFill, w_shiftIn[31:1]}        : w_shiftIn;
  assign w_stage2  = w_shiftAmount[1] ? {{2{w_shiftFill}}, w_stage1[31:2]}    : w_stage1;
  assign w_stage4  = w_shiftAmount[2] ? {{4{w_shiftFill}}, w_stage2[31:4]}    : w_stage2;
  assign w_stage8  = w_shiftAmount[3] ? {{8{w_shiftFill}}, w_stage4[31:8]}    : w_stage4;
  assign w_stage16 = w_shiftAmount[4] ? {{16{w_shiftFill}}, w_stage8[31:16]}  : w_stage8;

  // Mirror the barrel output back for SLL.
  always_comb begin
    w_reversedOut = '0;
    for (int i = 0; i < 32; i++) begin
      w_reversedOut[i] = w_stage16[31-i];
    end
  end

  assign w_shiftResult = w_isLeftShift ? w_reversedOut : w_stage16;

  // Result and carry/overflow selection.
  // Carry and overflow only carry meaning for ADD and SUB and are forced
  // low for every other operation, including the unused codes.
  logic [31:0] w_result;
  logic        w_carry;
  logic        w_overflow;

  // Choose the result for the current control code.
  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        w_result   = w_addSum[31:0];
        w_carry    = w_addSum[32];
        w_overflow = w_addOverflow;
      end
      OP_AND:   w_result = data_in1 & data_in2;
      OP_OR:    w_result = data_in1 | data_in2;
      OP_XOR:   w_result = data_in1 ^ data_in2;
      OP_NOR:   w_result = ~(data_in1 | data_in2);
      OP_SLTU:  w_result = {31'd0, w_lessUnsigned};
      OP_SLT:   w_result = {31'd0, w_lessSigned};
      OP_SLL, OP_SRL, OP_SRA: w_result = w_shiftResult;
      OP_PASSB: w_result = data_in2;
      default:  w_result = '0;
    endcase
  end

  // Capture result and flags each cycle; reset wins and discards the pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut  <= '0;
      r_zero     <= 1'b1;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_dataOut  <= w_result;
      r_zero     <= (w_result == 32'd0);
      r_negative <= w_result[31];
      r_carry    <= w_carry;
      r_overflow <= w_overflow;
    end
  end

  assign data_out = r_dataOut;
  assign zero     = r_zero;
  assign negative = r_negative;
  assign carry    = r_carry;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered 32-bit ALU.
// A behavioural model predicts each cycle's outputs from the inputs seen
// at the previous rising edge; directed vectors additionally carry
// hand-computed expectations.

module tb_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  control;
  logic [31:0] data_in1;
  logic [31:0] data_in2;
  logic [31:0] data_out;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int assertCount;
  int failCount;

  localparam logic [3:0] ADD   = 4'b0000;
  localparam logic [3:0] SUB   = 4'b0001;
  localparam logic [3:0] ANDOP = 4'b0010;
  localparam logic [3:0] OROP  = 4'b0100;
  localparam logic [3:0] XOROP = 4'b0110;
  localparam logic [3:0] NOROP = 4'b0111;
  localparam logic [3:0] SLTU  = 4'b1000;
  localparam logic [3:0] SRL   = 4'b1010;
  localparam logic [3:0] SRA   = 4'b1011;
  localparam logic [3:0] SLT   = 4'b1100;
  localparam logic [3:0] SLL   = 4'b1110;
  localparam logic [3:0] PASSB = 4'b1111;

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .control  (control),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_out (data_out),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour written straight from the operation definitions
  // using wide plain arithmetic.
  function automatic void aluModel(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] res,
                                   output logic c, output logic v);
    longint sa;
    longint sb;
    longint wide;
    longint unsigned usum;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ADD: begin
        usum = longint'(a) + longint'(b);
        res  = usum[31:0];
        c    = (usum > 64'h0000_0000_FFFF_FFFF);
        wide = sa + sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      SUB: begin
        res  = a - b;
        c    = (a >= b);
        wide = sa - sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      ANDOP: res = a & b;
      OROP:  res = a | b;
      XOROP: res = a ^ b;
      NOROP: res = ~(a | b);
      SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      SLT:   res = (sa < sb) ? 32'd1 : 32'd0;
      SLL:   res = a << b[4:0];
      SRL:   res = a >> b[4:0];
      SRA:   res = $unsigned($signed(a) >>> b[4:0]);
      PASSB: res = b;
      default: res = 32'd0;
    endcase
  endfunction

  logic [31:0] expData;
  logic        expZero;
  logic        expNeg;
  logic        expCarry;
  logic        expOvf;
  logic        modelValid;

  initial modelValid = 1'b0;

  // Predict the outputs that the coming edge will register.
  always @(posedge clk) begin
    logic [31:0] r;
    logic        c;
    logic        v;
    if (reset) begin
      r = 32'd0;
      c = 1'b0;
      v = 1'b0;
      expZero = 1'b1;
      expNeg  = 1'b0;
    end else begin
      aluModel(control, data_in1, data_in2, r, c, v);
      expZero = (r == 32'd0);
      expNeg  = r[31];
    end
    expData    = r;
    expCarry   = c;
    expOvf     = v;
    modelValid = 1'b1;
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (modelValid) begin
      assertCount++;
      if ({data_out, zero, negative, carry, overflow} !==
          {expData, expZero, expNeg, expCarry, expOvf}) begin
        failCount++;
        $display("[TB] FAIL model t=%0t got data=%h z%b n%b c%b v%b expected data=%h z%b n%b c%b v%b",
                 $time, data_out, zero, negative, carry, overflow,
                 expData, expZero, expNeg, expCarry, expOvf);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] d, input logic z,
                             input logic n, input logic c, input logic v);
    assertCount++;
    if ({data_out, zero, negative, carry, overflow} !== {d, z, n, c, v}) begin
      failCount++;
      $display("[TB] FAIL %s got data=%h z%b n%b c%b v%b expected data=%h z%b n%b c%b v%b",
               name, data_out, zero, negative, carry, overflow, d, z, n, c, v);
    end
  endtask

  // Drive one operation, then sample just after the edge that registers it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset    = 1'b0;
    control  = op;
    data_in1 = a;
    data_in2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset    = 1'b1;
    control  = 4'($urandom);
    data_in1 = $urandom;
    data_in2 = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] unusedCodes [4];
    assertCount = 0;
    failCount   = 0;
    reset    = 1'b1;
    control  = 4'd0;
    data_in1 = 32'd0;
    data_in2 = 32'd0;
    unusedCodes[0] = 4'b0011;
    unusedCodes[1] = 4'b0101;
    unusedCodes[2] = 4'b1001;
    unusedCodes[3] = 4'b1101;

    applyReset();
    checkOutput("reset1", 32'd0, 1, 0, 0, 0);
    applyReset();
    checkOutput("reset2", 32'd0, 1, 0, 0, 0);

    applyStimulus(ADD, 32'd6, 32'd2);   checkOutput("add6_2",  32'd8,  0, 0, 0, 0);
    applyStimulus(SUB, 32'd6, 32'd2);   checkOutput("sub6_2",  32'd4,  0, 0, 1, 0);
    applyStimulus(SLL, 32'd6, 32'd2);   checkOutput("sll6_2",  32'd24, 0, 0, 0, 0);
    applyStimulus(SLT, 32'd6, 32'd2);   checkOutput("slt6_2",  32'd0,  1, 0, 0, 0);
    applyStimulus(SLTU, 32'd6, 32'd2);  checkOutput("sltu6_2", 32'd0,  1, 0, 0, 0);
    applyStimulus(ANDOP, 32'd6, 32'd2); checkOutput("and6_2",  32'd2,  0, 0, 0, 0);
    applyStimulus(SRL, 32'd6, 32'd2);   checkOutput("srl6_2",  32'd1,  0, 0, 0, 0);
    applyStimulus(PASSB, 32'd6, 32'd2); checkOutput("passb",   32'd2,  0, 0, 0, 0);

    applyStimulus(SRA, 32'hF000_0006, 32'd2);   checkOutput("sra_neg", 32'hFC00_0001, 0, 1, 0, 0);
    applyStimulus(OROP, 32'hF000_0006, 32'd2);  checkOutput("or_neg",  32'hF000_0006, 0, 1, 0, 0);
    applyStimulus(XOROP, 32'hF000_0006, 32'd2); checkOutput("xor_neg", 32'hF000_0004, 0, 1, 0, 0);
    applyStimulus(NOROP, 32'hF000_0006, 32'd2); checkOutput("nor_neg", 32'h0FFF_FFF9, 0, 0, 0, 0);
    applyStimulus(SLT, 32'hF000_0006, 32'd2);   checkOutput("slt_neg", 32'd1, 0, 0, 0, 0);
    applyStimulus(SLTU, 32'hF000_0006, 32'd2);  checkOutput("sltu_neg", 32'd0, 1, 0, 0, 0);

    applyStimulus(ADD, 32'h7FFF_FFFF, 32'd1); checkOutput("add_ovf",   32'h8000_0000, 0, 1, 0, 1);
    applyStimulus(ADD, 32'hFFFF_FFFF, 32'd1); checkOutput("add_carry", 32'd0,         1, 0, 1, 0);
    applyStimulus(SUB, 32'd5, 32'd5);         checkOutput("sub_zero",  32'd0,         1, 0, 1, 0);
    applyStimulus(SUB, 32'd0, 32'd1);         checkOutput("sub_borrow", 32'hFFFF_FFFF, 0, 1, 0, 0);
    applyStimulus(SUB, 32'h8000_0000, 32'd1); checkOutput("sub_ovf",   32'h7FFF_FFFF, 0, 0, 1, 1);

    applyStimulus(SRA, 32'h8000_0000, 32'd31); checkOutput("sra31",  32'hFFFF_FFFF, 0, 1, 0, 0);
    applyStimulus(SRL, 32'h8000_0000, 32'd31); checkOutput("srl31",  32'd1,         0, 0, 0, 0);
    applyStimulus(SLL, 32'h8000_0000, 32'd0);  checkOutput("sll0",   32'h8000_0000, 0, 1, 0, 0);
    applyStimulus(SRL, 32'h8000_0000, 32'd32); checkOutput("srl32",  32'h8000_0000, 0, 1, 0, 0);
    applyStimulus(SLL, 32'h0000_0001, 32'd31); checkOutput("sll31",  32'h8000_0000, 0, 1, 0, 0);

    foreach (unusedCodes[i]) begin
      applyStimulus(unusedCodes[i], 32'h1234_5678, 32'h9ABC_DEF0);
      checkOutput("unused", 32'd0, 1, 0, 0, 0);
    end

    // Reset mid-stream discards the pending result, and the first cycle
    // after reset already returns a real result.
    applyStimulus(ADD, 32'd100, 32'd23); checkOutput("pre_reset", 32'd123, 0, 0, 0, 0);
    applyReset();
    checkOutput("mid_reset", 32'd0, 1, 0, 0, 0);
    applyStimulus(SUB, 32'd10, 32'd3);  checkOutput("post_reset", 32'd7, 0, 0, 1, 0);

    for (int k = 0; k < 200; k++) begin
      applyStimulus(4'($urandom), $urandom, (k % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU with registered result and status flags, used in the processor execute stage.
- A 4-bit control code selects one of 12 operations on two 32-bit operands.
- Result and flags are captured on the rising clock edge, so latency is 1 cycle.

Parameters:
- None. Data width is fixed at 32 bits and control width at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all outputs
- control  input  4  operation select
- data_in1  input  32  operand A
- data_in2  input  32  operand B; only bits [4:0] are used as the shift amount
- data_out  output  32  registered result
- zero  output  1  registered; 1 when the result is 0
- negative  output  1  registered; copy of result bit 31
- carry  output  1  registered; carry-out for ADD, no-borrow for SUB, 0 otherwise
- overflow  output  1  registered; signed overflow for ADD/SUB, 0 otherwise

Behaviour:
- Reset is synchronous and active-high. On any rising edge with reset=1: data_out=0, zero=1, negative=0, carry=0, overflow=0.
- Reset has priority over the operation. A reset asserted mid-stream discards the pending result.
- Otherwise, each rising edge registers the result of the current control/data_in1/data_in2.
- Outputs reflect the inputs present at the previous edge (1-cycle latency). There is no handshake; a new operation is accepted every cycle.
- Operation encoding:
  - 0000 ADD: A+B, modulo 2^32
  - 0001 SUB: A-B, modulo 2^32
  - 0010 AND: A&B
  - 0100 OR: A|B
  - 0110 XOR: A^B
  - 0111 NOR: ~(A|B)
  - 1000 SLTU: 1 if A<B unsigned, else 0
  - 1100 SLT: 1 if A<B signed (two's complement), else 0
  - 1110 SLL: A << B[4:0], zero fill
  - 1010 SRL: A >> B[4:0], zero fill
  - 1011 SRA: A >> B[4:0], sign fill from A[31]
  - 1111 PASSB: B
  - Unused codes 0011, 0101, 1001, 1101: result 0, so zero=1.
- SLT/SLTU results are zero-extended to 32 bits.
- Shift amount 0 returns A unchanged. Upper bits B[31:5] are ignored, so B=32 shifts by 0.
- Carry/overflow:
  - ADD: carry = bit 32 of the 33-bit sum. Overflow = operands have the same sign and the result sign differs.
  - SUB: computed as A + ~B + 1. Carry = bit 32 (1 means no borrow). Overflow = operands have different signs and the result sign differs from A.
- zero and negative are derived from the same result that is registered into data_out.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> data_out=0, zero=1, other flags 0; the first post-reset cycle gives the correct result.
- A=6, B=2 across the codes, one per cycle, each checked 1 cycle after it is applied:
  - ADD -> 8
  - SUB -> 4
  - SLL -> 24
  - SLT -> 0
  - SLTU -> 0
  - AND -> 2
  - SRL -> 1
  - PASSB -> 2
- A=F0000006, B=2:
  - SRA -> FC000001, negative=1
  - OR -> F0000006
  - XOR -> F0000004
  - NOR -> 0FFFFFF9
  - SLT -> 1
  - SLTU -> 0
- Flags:
  - ADD 7FFFFFFF+1 -> 80000000, overflow=1, carry=0, negative=1
  - ADD FFFFFFFF+1 -> 0, carry=1, zero=1
  - SUB 5-5 -> 0, zero=1, carry=1
  - SUB 0-1 -> FFFFFFFF, carry=0
- Shift limits with A=80000000:
  - SRA by 31 -> FFFFFFFF
  - SRL by 31 -> 1
  - SLL by 0 -> 80000000
  - B=00000020 -> treated as a shift of 0
- Unused codes 0011/0101/1001/1101 with nonzero A and B -> data_out=0, zero=1.
